// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay driver: FSM state encoding and ms-to-cycle conversion.
package relay_pkg;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_ON_HOLD  = 3'd1,
    S_ON       = 3'd2,
    S_OFF_HOLD = 3'd3,
    S_FAULT    = 3'd4
  } relay_state_t;

  // 64-bit math: 50 kHz-per-ms times a 300 s cutoff overflows 32 bits.
  function automatic longint unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                   input longint unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/relay_driver_if.sv
// Command/status bundle between the brew controller (master) and the relay driver (slave).
// Handshake: none -- cmd_on is a level sampled every clk; relay_out/busy/fault are registered levels.
interface relay_driver_if;
  logic cmd_on;
  logic fault_clr;
  logic relay_out;
  logic busy;
  logic fault;

  modport master (output cmd_on, output fault_clr, input relay_out, input busy, input fault);
  modport slave  (input cmd_on, input fault_clr, output relay_out, output busy, output fault);
endinterface

// File: rtl/relay_driver_dwell_timer.sv
// Clear/enable up-counter that saturates at LIMIT-1; done_o is high while the count sits there.
module dwell_timer #(
  parameter longint unsigned LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == LAST);

endmodule

// File: rtl/relay_driver.sv
// Relay driver enforcing minimum on/off dwell times on a clean command level.
// Optional max-on cutoff with latched fault when RELAY_DRIVER_SAFETY_TIMEOUT_EN is defined.
module relay_driver
  import relay_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned MIN_ON_MS  = 100,
  parameter int unsigned MIN_OFF_MS = 100,
  parameter int unsigned MAX_ON_MS  = 300_000
) (
  input  logic                 clk,
  input  logic                 rst,
  relay_driver_if.slave        relay_if,
  output relay_state_t         dbg_state_o
);

  localparam longint unsigned MIN_ON_CNT  = ms_to_cycles(CLK_HZ, MIN_ON_MS);
  localparam longint unsigned MIN_OFF_CNT = ms_to_cycles(CLK_HZ, MIN_OFF_MS);
  localparam longint unsigned MAX_ON_CNT  = ms_to_cycles(CLK_HZ, MAX_ON_MS);

  if (MIN_ON_CNT < 1) begin : g_bad_min_on
    $fatal(1, "relay_driver: MIN_ON_CNT must be at least 1");
  end
  if (MIN_OFF_CNT < 1) begin : g_bad_min_off
    $fatal(1, "relay_driver: MIN_OFF_CNT must be at least 1");
  end

  relay_state_t state_q, state_d;
  logic relay_q, busy_q, fault_q;
  logic on_done, off_done, max_done;
  logic fault_clr_w;

  dwell_timer #(.LIMIT(MIN_ON_CNT)) u_on_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != S_ON_HOLD),
    .en_i   (state_q == S_ON_HOLD),
    .done_o (on_done)
  );

  dwell_timer #(.LIMIT(MIN_OFF_CNT)) u_off_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != S_OFF_HOLD),
    .en_i   (state_q == S_OFF_HOLD),
    .done_o (off_done)
  );

`ifdef RELAY_DRIVER_SAFETY_TIMEOUT_EN
  if (MAX_ON_CNT <= MIN_ON_CNT) begin : g_bad_max_on
    $fatal(1, "relay_driver: MAX_ON_CNT must exceed MIN_ON_CNT");
  end

  // Runs for every cycle the relay is energised; held at zero while it is low.
  dwell_timer #(.LIMIT(MAX_ON_CNT)) u_max_on (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!relay_q),
    .en_i   (relay_q),
    .done_o (max_done)
  );

  assign fault_clr_w = relay_if.fault_clr;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = relay_if.fault_clr;
  assign max_done         = 1'b0;
  assign fault_clr_w      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF: begin
        if (relay_if.cmd_on) state_d = S_ON_HOLD;
      end
      S_ON_HOLD: begin
        if (max_done) begin
          state_d = S_FAULT;
        end else if (on_done) begin
          state_d = relay_if.cmd_on ? S_ON : S_OFF_HOLD;
        end
      end
      S_ON: begin
        if (max_done) begin
          state_d = S_FAULT;
        end else if (!relay_if.cmd_on) begin
          state_d = S_OFF_HOLD;
        end
      end
      S_OFF_HOLD: begin
        if (off_done) state_d = relay_if.cmd_on ? S_ON_HOLD : S_OFF;
      end
      S_FAULT: begin
        if (fault_clr_w && !relay_if.cmd_on) state_d = S_OFF_HOLD;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Outputs are registered alongside the state, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      relay_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      relay_q <= (state_d == S_ON_HOLD) || (state_d == S_ON);
      busy_q  <= (state_d == S_ON_HOLD) || (state_d == S_OFF_HOLD);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign relay_if.relay_out = relay_q;
  assign relay_if.busy      = busy_q;
  assign relay_if.fault     = fault_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_relay_driver.sv
// Bench for relay_driver: directed scenarios then random command levels, checked against a
// behavioural model of dwell rules expressed as run lengths of the output level.
module tb_relay_driver;
  import relay_pkg::*;

  localparam int MIN_ON  = 4;
  localparam int MIN_OFF = 3;
  localparam int MAX_ON  = 10;
`ifdef RELAY_DRIVER_SAFETY_TIMEOUT_EN
  localparam bit SAFETY = 1'b1;
`else
  localparam bit SAFETY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relay_driver_if relay_if ();
  relay_state_t   dbg_state;

  relay_driver #(
    .CLK_HZ    (1000),
    .MIN_ON_MS (MIN_ON),
    .MIN_OFF_MS(MIN_OFF),
    .MAX_ON_MS (MAX_ON)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .relay_if   (relay_if),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  // m_run: cycles the output has shown its current level (1 on the first such cycle).
  bit m_relay, m_fault, m_offdwell;
  int m_run;

  function automatic void model_reset();
    m_relay    = 1'b0;
    m_fault    = 1'b0;
    m_offdwell = 1'b0;
    m_run      = 0;
  endfunction

  function automatic logic [2:0] model_out();
    bit busy;
    if (m_fault)      busy = 1'b0;
    else if (m_relay) busy = (m_run <= MIN_ON);
    else              busy = m_offdwell && (m_run <= MIN_OFF);
    return {m_relay, busy, m_fault};
  endfunction

  function automatic void model_step(bit c, bit f);
    if (m_fault) begin
      if (f && !c) begin
        m_fault = 1'b0; m_relay = 1'b0; m_run = 1; m_offdwell = 1'b1;
      end
    end else if (m_relay) begin
      if (SAFETY && m_run >= MAX_ON) begin
        m_fault = 1'b1; m_relay = 1'b0; m_run = 0; m_offdwell = 1'b0;
      end else if (m_run < MIN_ON || c) begin
        m_run++;
      end else begin
        m_relay = 1'b0; m_run = 1; m_offdwell = 1'b1;
      end
    end else begin
      if (m_offdwell && m_run < MIN_OFF) begin
        m_run++;
      end else if (c) begin
        m_relay = 1'b1; m_run = 1;
      end else begin
        m_run++;
      end
    end
    if (m_run > 1000) m_run = 1000;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic check_out(input string tag, input logic [2:0] exp);
    logic [2:0] got;
    got = {relay_if.relay_out, relay_if.busy, relay_if.fault};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: {relay,busy,fault} got %b expected %b", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit c, input bit f, input string tag);
    relay_if.cmd_on    = c;
    relay_if.fault_clr = f;
    @(posedge clk);
    model_step(c, f);
    exp_q.push_back(model_out());
    #1;
    check_out(tag, exp_q.pop_front());
  endtask

  task automatic run_n(input bit c, input bit f, input int n, input string tag);
    repeat (n) step(c, f, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit cur;
    rst = 1'b1;
    relay_if.cmd_on    = 1'b0;
    relay_if.fault_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 3'b000);
    rst = 1'b0;
    run_n(0, 0, 3, "idle");

    // reset asserted asynchronously in the middle of an on-hold
    run_n(1, 0, 2, "pre_rst_hold");
    #2 rst = 1'b1;
    #1;
    check_out("rst_mid_hold", 3'b000);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run_n(0, 0, 2, "post_rst");

    // held command: 4 busy cycles then steady on
    run_n(1, 0, 8, "hold_on");
    check_out("hold_on_steady", 3'b100);
    run_n(0, 0, 6, "release");

    // one-cycle pulse from idle
    step(1, 0, "pulse");
    run_n(0, 0, 9, "pulse_tail");

    // drop and immediately re-raise while in steady on
    run_n(1, 0, 6, "to_on");
    step(0, 0, "drop");
    run_n(1, 0, 6, "reraise");

    // long hold: fault with cutoff, steady on without it
    run_n(1, 0, 50, "long_hold");
`ifdef RELAY_DRIVER_SAFETY_TIMEOUT_EN
    check_out("fault_latched", 3'b001);
    run_n(1, 1, 2, "clr_while_cmd");
    check_out("clr_ignored", 3'b001);
    step(0, 1, "clr_ok");
    check_out("clr_offdwell", 3'b010);
    run_n(0, 0, 4, "after_clr");
`else
    check_out("no_cutoff", 3'b100);
    run_n(0, 1, 6, "after_hold");
`endif

    // randomized command levels with occasional fault_clr
    cur = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) cur = ~cur;
      step(cur, ($urandom_range(0, 3) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
